// File: rtl/rcs_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Imported by the controller and the arithmetic slice.
package rcs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int RCS_SLICE_W = 4;

endpackage

// File: rtl/rcs_slice_4bit.sv
// Combinational 4-bit ripple-borrow subtractor slice.
// Computes {bout, diff} = a - b - bin.
module rcs_slice_4bit
  import rcs_pkg::*;
(
  input  logic [RCS_SLICE_W-1:0] a,
  input  logic [RCS_SLICE_W-1:0] b,
  input  logic                   bin,
  output logic [RCS_SLICE_W-1:0] diff,
  output logic                   bout
);

  logic [RCS_SLICE_W:0] br;

  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int i = 0; i < RCS_SLICE_W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i])
               | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[RCS_SLICE_W];
  end

endmodule

// File: rtl/rcs_seq_ctrl.sv
// Nibble-serial wide subtractor controller: one slice,
// LSB nibble first, registered borrow chained across cycles.
module rcs_seq_ctrl
  import rcs_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   borrow,
  output logic                   zero
);

  localparam int W  = RCS_SLICE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state;

  logic [IW-1:0]          idx;
  logic [W-1:0]           a_q;
  logic [W-1:0]           b_q;
  logic [RCS_SLICE_W-1:0] an;
  logic [RCS_SLICE_W-1:0] bn;
  logic [RCS_SLICE_W-1:0] sd;
  logic                   sb;

  always_comb begin
    an = '0;
    bn = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        an = a_q[i*RCS_SLICE_W +: RCS_SLICE_W];
        bn = b_q[i*RCS_SLICE_W +: RCS_SLICE_W];
      end
    end
  end

  rcs_slice_4bit u_slice (
    .a    (an),
    .b    (bn),
    .bin  (borrow),
    .diff (sd),
    .bout (sb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            diff   <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i))
              diff[i*RCS_SLICE_W +: RCS_SLICE_W] <= sd;
          end
          borrow <= sb;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state != RUN);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign zero  = ~|diff;

endmodule

// File: tb/tb_rcs_seq_ctrl.sv
// Self-checking bench for rcs_seq_ctrl (NIBBLES=4).
// Directed steps plus random ops against an arithmetic model.
module tb_rcs_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rcs_seq_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic chk_res(input string tag,
                         input logic [15:0] x,
                         input logic [15:0] y);
    logic [16:0] r;
    r = {1'b0, x} - {1'b0, y};
    chk({tag, "_diff"}, 32'(diff), 32'(r[15:0]));
    chk({tag, "_borrow"}, 32'(borrow), 32'(r[16]));
    chk({tag, "_zero"}, 32'(zero), 32'(r[15:0] == 16'h0));
  endtask

  // Full operation: accept, four busy cycles, done pulse, hold.
  task automatic do_op(input string tag,
                       input logic [15:0] x,
                       input logic [15:0] y);
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy"}, 32'(ready), 32'd0);
      chk({tag, "_early"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_dbusy"}, 32'(busy), 32'd0);
    chk({tag, "_drdy"}, 32'(ready), 32'd1);
    chk_res(tag, x, y);
    tick();
    chk_idle({tag, "_after"});
    chk_res({tag, "_hold"}, x, y);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_diff", 32'(diff), 32'h0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    tick();

    do_op("basic", 16'h1234, 16'h0234);
    tick();
    tick();
    chk_res("basic_idle", 16'h1234, 16'h0234);

    do_op("ripple", 16'h0000, 16'h0001);
    do_op("ripple2", 16'h8000, 16'h0FFF);
    do_op("equal", 16'hABCD, 16'hABCD);

    // start pulsed mid-run with other operands is ignored
    a = 16'h0100;
    b = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hFFFF;
    b = 16'h1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ign_done", 32'(done), 32'd1);
    chk_res("ign", 16'h0100, 16'h0001);
    tick();
    chk_idle("ign_after");

    // back-to-back via DONE
    a = 16'h4000;
    b = 16'h1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    a = 16'h0005;
    b = 16'h0003;
    start = 1'b1;
    tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk_res("b2b1", 16'h4000, 16'h1000);
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_nodone", 32'(done), 32'd0);
    tick();
    tick();
    tick();
    chk("b2b_busy3", 32'(busy), 32'd1);
    tick();
    chk("b2b_done2", 32'(done), 32'd1);
    chk_res("b2b2", 16'h0005, 16'h0003);
    tick();

    // reset in the middle of a run
    a = 16'h1234;
    b = 16'h0234;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk_idle("mrst");
    chk("mrst_diff", 32'(diff), 32'h0);
    chk("mrst_borrow", 32'(borrow), 32'd0);
    chk("mrst_zero", 32'(zero), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_nodone", 32'(done), 32'd0);
      chk("mrst_nobusy", 32'(busy), 32'd0);
    end
    do_op("post", 16'h00FF, 16'h000F);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      x = 16'($urandom);
      y = (i % 5 == 0) ? x : 16'($urandom);
      do_op("rand", x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rcs_seq_ctrl.md
# rcs_seq_ctrl

Nibble-serial wide subtractor controller. It computes `a - b` on `4*NIBBLES`-bit unsigned operands by time-sharing a single 4-bit ripple-carry subtractor slice, one nibble per clock, LSB first. A registered borrow chains between nibbles. The block sits between a requester (start/done handshake) and the arithmetic slice, trading latency for area versus a full-width ripple subtractor.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range ≥ 1.

Ports:
- `clk`  in  1  rising-edge clock, sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `ready`=1
- `a`  in  W  minuend, captured on accepted start
- `b`  in  W  subtrahend, captured on accepted start
- `ready`  out  1  controller can accept `start`
- `busy`  out  1  subtraction in progress
- `done`  out  1  one-cycle pulse, result valid
- `diff`  out  W  (a − b) mod 2^W
- `borrow`  out  1  final borrow; 1 iff a < b (unsigned)
- `zero`  out  1  1 iff `diff` == 0 (valid with/after `done`)

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `ready`=1, `busy`=0, `done`=0.
  - `start`=1 → capture `a`, `b`; clear borrow register, nibble index and `diff`; go to RUN.
- **RUN**
  - `ready`=0, `busy`=1.
  - Each cycle the slice gets nibble[idx] of `a`, nibble[idx] of `b`, and the registered borrow.
  - Slice difference is written into `diff` nibble[idx]; slice borrow-out is registered; idx increments.
  - After idx = NIBBLES−1 is processed → DONE.
  - `start` ignored.
- **DONE**
  - `done`=1 for exactly this cycle; `ready`=1, `busy`=0.
  - `borrow` = final registered borrow.
  - `start`=1 here is accepted exactly as in IDLE (back-to-back) → RUN; otherwise → IDLE.
- Result holding: `diff`, `borrow`, `zero` hold the last result until the next accepted start, which clears them to 0.
- Slice arithmetic, per nibble: {bout, d[3:0]} = {1'b0, a_n} − {1'b0, b_n} − bin, with bout = 1 when the true result is negative.
- Nibble index counter: width max(1, $clog2(NIBBLES)); never exceeds NIBBLES−1.
- `rst` (any state, including mid-RUN): state → IDLE; `diff`=0, `borrow`=0, `done`=0, `busy`=0, `ready`=1, index=0, captured operands=0. `zero` reflects `diff`=0, so it reads 1.
- `rst` and `start` in the same cycle: reset wins, start is dropped.

## Timing
- Edge E0 samples `start` with `ready`=1 → RUN.
- Edges E1..E_NIBBLES process nibbles 0..NIBBLES−1.
- After E_NIBBLES: DONE, `done`=1.
- Latency from the accepting edge to `done` high: NIBBLES cycles. Throughput: one operation per NIBBLES+1 cycles (back-to-back via DONE).
- Outputs are all registered or decoded from state/registers; no combinational path from `a`/`b`/`start` to any output.
- `NIBBLES`=1: a single RUN cycle, then DONE.

## Structure
- Shared package `rcs_pkg`:
  - state enum (IDLE, RUN, DONE)
  - constant `RCS_SLICE_W` = 4
- One sub-module, `rcs_slice_4bit`:
  - combinational 4-bit ripple-carry subtractor with borrow-in.
  - ports: `a[3:0]`, `b[3:0]`, `bin`, `diff[3:0]`, `bout`.
  - instantiated once.
- Controller holds the FSM, index counter, operand registers, borrow register and the `diff` nibble write-back.

## Test plan
All with NIBBLES=4.
- Reset: assert `rst` 2 cycles → `ready`=1, `busy`=0, `done`=0, `diff`=0x0000, `borrow`=0, `zero`=1.
- Basic: `a`=0x1234, `b`=0x0234, start → `busy` high 4 cycles, then `done` pulse 1 cycle with `diff`=0x1000, `borrow`=0, `zero`=0; values hold while idle.
- Full borrow ripple: `a`=0x0000, `b`=0x0001 → `diff`=0xFFFF, `borrow`=1. Also `a`=0x8000, `b`=0x0FFF → `diff`=0x7001, `borrow`=0.
- Equal operands: `a`=`b`=0xABCD → `diff`=0x0000, `borrow`=0, `zero`=1.
- Handshake:
  - `start` pulsed during RUN with new operands → ignored, result unchanged.
  - `start` held through DONE with `a`=0x0005, `b`=0x0003 → second op accepted with no IDLE cycle; `done` again 4 cycles later with `diff`=0x0002.
- Mid-op reset: `rst` after 2 RUN cycles of 0x1234−0x0234 → IDLE next cycle, outputs at reset values, no `done`. A following 0x00FF−0x000F op gives `diff`=0x00F0.
